sfp_link_bringup_seq: RTL
=========================

// Module: sfp_link_bringup_seq
// PURPOSE
//  Multi-channel bring-up and reset sequencer for 10G SFP PHY channels, running in the 50 MHz management domain.
//  Qualifies each channel on PLL lock, reconfig idle, tx_ready and rx_ready, with synchronisers and a stability hold.
//  Retries stuck channels by pulsing a per-channel PHY reset. Drives per-channel user_rst into the xgmii-domain sync_reset.
//  Counts link flaps for status and LED display.
// PARAMETERS
//  N_CH            2          number of SFP channels (>=1)
//  SYNC_STAGES     2          synchroniser depth on every async input (>=2)
//  HOLD_CYCLES     1024       qualifiers must stay true this many cycles before link_up
//  TIMEOUT_CYCLES  5000000    max cycles in WAIT+HOLD before PHY reset retry (100 ms @50 MHz)
//  PHY_RST_CYCLES  64         width of phy_rst pulse
//  FLAP_W          8          width of each saturating flap counter
// PORTS
//  clk            in   1            management clock (50 MHz)
//  sys_rst_n      in   1            asynchronous, active-low reset
//  pll_locked     in   1            async; shared PHY PLL lock
//  reconfig_busy  in   1            async; shared reconfig controller busy
//  tx_ready       in   N_CH         async; per-channel PHY tx ready
//  rx_ready       in   N_CH         async; per-channel PHY rx ready / block lock
//  clr_flap       in   1            sync; clears all flap counters
//  phy_rst        out  N_CH         per-channel PHY channel reset, active-high
//  user_rst       out  N_CH         per-channel datapath reset, active-high
//  link_up        out  N_CH         per-channel link qualified
//  flap_cnt       out  N_CH*FLAP_W  ch i at [i*FLAP_W +: FLAP_W]
// BEHAVIOUR
//  - Every async input passes through a SYNC_STAGES flop chain, reset to 0. Sync values are written with the _s suffix.
//  - qual[i] = pll_locked_s & ~reconfig_busy_s & tx_ready_s[i] & rx_ready_s[i].
//  - tq[i] = pll_locked_s & ~reconfig_busy_s & tx_ready_s[i].
//  - Each channel has an independent FSM with state S_RST, hold counter hcnt, and timeout counter tcnt. Counter widths come from $clog2.
//  - S_RST: always go to S_WAIT next cycle; clear tcnt and hcnt.
//  - S_WAIT: if tcnt==TIMEOUT_CYCLES-1, go to S_PHYRST. Otherwise, if qual, go to S_HOLD with hcnt=0. tcnt increments.
//  - S_HOLD: if tcnt==TIMEOUT_CYCLES-1, go to S_PHYRST (timeout has priority). Otherwise:
//      ~qual goes to S_WAIT; tcnt is NOT cleared, so a flapping rx still times out.
//      qual with hcnt==HOLD_CYCLES-1 goes to S_UP.
//      Otherwise hcnt++. tcnt increments in both branches.
//  - S_UP: if ~qual, go to S_RST and increment flap_cnt[i]; otherwise stay.
//  - S_PHYRST: pcnt counts PHY_RST_CYCLES cycles, then go to S_RST.
//  - Outputs are decoded from the state registers (no extra register stage):
//      phy_rst  = (state==S_PHYRST)
//      user_rst = (state!=S_UP)
//      link_up  = (state==S_UP)
//  - Reset (sys_rst_n low, any time, async): all FSMs to S_RST, all counters 0, sync chains 0.
//      Outputs during reset: phy_rst=0, user_rst=all 1, link_up=0, flap_cnt=0.
//  - Latency: with the channel in S_WAIT and raw inputs becoming qualified, link_up rises exactly SYNC_STAGES+1+HOLD_CYCLES clk edges later.
//  - Latency: a raw qualifier drop in S_UP deasserts link_up (and asserts user_rst) SYNC_STAGES+1 edges later.
//  - flap_cnt saturates at all-ones. If clr_flap and an increment occur in the same cycle, clear wins (result 0).
//  - Channels are fully independent. A shared input (pll_locked or reconfig_busy) dropping knocks every S_UP channel down in the same cycle.
//  - Loss of tx_ready alone while in S_HOLD behaves like any qual drop.
// TESTING (bench params: N_CH=2, SYNC_STAGES=2, HOLD_CYCLES=8, TIMEOUT_CYCLES=100, PHY_RST_CYCLES=4, FLAP_W=4)
//  1. Bring-up: release reset, then set all inputs good (busy=0) at edge 10.
//     -> link_up=2'b11 and user_rst=2'b00 from edge 21; phy_rst never asserts.
//  2. Glitch in hold: ch0 rx_ready low for 1 cycle mid-S_HOLD.
//     -> ch0 returns to S_WAIT, hcnt restarts; link_up is delayed. ch1 is unaffected.
//  3. Timeout: ch1 rx_ready held 0.
//     -> phy_rst[1] high for exactly 4 cycles, 100 cycles after entering S_WAIT; repeats every 105 cycles. ch0 stays up.
//  4. Flap: with both up, pulse pll_locked low 3 cycles.
//     -> both link_up drop 3 edges later, flap_cnt = {4'd1,4'd1}, both re-qualify.
//  5. Saturation and clear: force 16 flaps on ch0 -> flap_cnt[3:0]=4'hF.
//     Then clr_flap on the same cycle as a flap -> 4'h0.
//  6. Async reset mid-S_PHYRST: assert sys_rst_n=0.
//     -> phy_rst=0 and user_rst=2'b11 immediately (no clk edge needed); counters 0.

Source files
------------

// File: rtl/sfp_link_bringup_seq.sv
// sfp_link_bringup_seq: per-channel SFP PHY bring-up, retry and flap counting.
// Runs in the management clock domain; all PHY status inputs are asynchronous.
module sfp_link_bringup_seq #(
   parameter int N_CH           = 2,
   parameter int SYNC_STAGES    = 2,
   parameter int HOLD_CYCLES    = 1024,
   parameter int TIMEOUT_CYCLES = 5000000,
   parameter int PHY_RST_CYCLES = 64,
   parameter int FLAP_W         = 8
) (
   input  logic                     clk,
   input  logic                     sys_rst_n,
   input  logic                     pll_locked,
   input  logic                     reconfig_busy,
   input  logic [N_CH-1:0]          tx_ready,
   input  logic [N_CH-1:0]          rx_ready,
   input  logic                     clr_flap,
   output logic [N_CH-1:0]          phy_rst,
   output logic [N_CH-1:0]          user_rst,
   output logic [N_CH-1:0]          link_up,
   output logic [N_CH*FLAP_W-1:0]   flap_cnt
);

   localparam int SW = 2*N_CH + 2;
   localparam int HW =
      (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int TW =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int PW =
      (PHY_RST_CYCLES > 1) ? $clog2(PHY_RST_CYCLES) : 1;

   localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [PW-1:0] P_LAST = PW'(PHY_RST_CYCLES - 1);

   typedef enum logic [2:0] {
      S_RST,
      S_WAIT,
      S_HOLD,
      S_UP,
      S_PHYRST
   } state_t;

   logic [SW-1:0]                  raw;
   logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
   logic                           pll_locked_s;
   logic                           reconfig_busy_s;
   logic [N_CH-1:0]                tx_ready_s;
   logic [N_CH-1:0]                rx_ready_s;
   logic [N_CH-1:0]                qual;

   assign raw = {rx_ready, tx_ready, reconfig_busy, pll_locked};

   // Flop chain bringing every async status input into clk
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      end
   end

   assign pll_locked_s    = sync_q[SYNC_STAGES-1][0];
   assign reconfig_busy_s = sync_q[SYNC_STAGES-1][1];
   assign tx_ready_s      = sync_q[SYNC_STAGES-1][N_CH+1:2];
   assign rx_ready_s      = sync_q[SYNC_STAGES-1][SW-1:N_CH+2];

   assign qual = {N_CH{pll_locked_s & ~reconfig_busy_s}}
               & tx_ready_s & rx_ready_s;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      state_t              st, st_n;
      logic [HW-1:0]       hcnt, hcnt_n;
      logic [TW-1:0]       tcnt, tcnt_n;
      logic [PW-1:0]       pcnt, pcnt_n;
      logic [FLAP_W-1:0]   fcnt, fcnt_n;

      // Channel state and counter registers
      always_ff @(posedge clk or negedge sys_rst_n) begin
         if (!sys_rst_n) begin
            st   <= S_RST;
            hcnt <= '0;
            tcnt <= '0;
            pcnt <= '0;
            fcnt <= '0;
         end else begin
            st   <= st_n;
            hcnt <= hcnt_n;
            tcnt <= tcnt_n;
            pcnt <= pcnt_n;
            fcnt <= fcnt_n;
         end
      end

      // Qualify, hold, time out and retry; tcnt survives HOLD->WAIT
      always_comb begin
         st_n   = st;
         hcnt_n = hcnt;
         tcnt_n = tcnt;
         pcnt_n = pcnt;
         fcnt_n = fcnt;
         unique case (st)
            S_RST: begin
               st_n   = S_WAIT;
               hcnt_n = '0;
               tcnt_n = '0;
               pcnt_n = '0;
            end
            S_WAIT: begin
               tcnt_n = tcnt + 1'b1;
               if (tcnt == T_LAST) begin
                  st_n   = S_PHYRST;
                  pcnt_n = '0;
               end else if (qual[i]) begin
                  st_n   = S_HOLD;
                  hcnt_n = '0;
               end
            end
            S_HOLD: begin
               tcnt_n = tcnt + 1'b1;
               if (tcnt == T_LAST) begin
                  st_n   = S_PHYRST;
                  pcnt_n = '0;
               end else if (!qual[i]) begin
                  st_n = S_WAIT;
               end else if (hcnt == H_LAST) begin
                  st_n = S_UP;
               end else begin
                  hcnt_n = hcnt + 1'b1;
               end
            end
            S_UP: begin
               if (!qual[i]) begin
                  st_n = S_RST;
                  if (fcnt != '1) fcnt_n = fcnt + 1'b1;
               end
            end
            S_PHYRST: begin
               if (pcnt == P_LAST) st_n = S_RST;
               else pcnt_n = pcnt + 1'b1;
            end
            default: st_n = S_RST;
         endcase
         if (clr_flap) fcnt_n = '0;
      end

      assign phy_rst[i]  = (st == S_PHYRST);
      assign user_rst[i] = (st != S_UP);
      assign link_up[i]  = (st == S_UP);
      assign flap_cnt[i*FLAP_W +: FLAP_W] = fcnt;
   end

endmodule
